// File: rtl/booth_mult_seq_pkg.sv
// Shared definitions for the radix-4 Booth sequential multiplier:
// default width, FSM state codes, Booth select encoding and helpers.
package booth_mult_seq_pkg;

   localparam int WIDTH_DEF = 32;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [2:0] {
      SEL_ZERO = 3'd0,
      SEL_PM   = 3'd1,
      SEL_P2M  = 3'd2,
      SEL_NM   = 3'd3,
      SEL_N2M  = 3'd4
   } booth_sel_e;

   function automatic int cnt_width(input int w);
      return $clog2(w / 2) + 1;
   endfunction

   // Overlapping triplet {b[i+1], b[i], b[i-1]} -> signed digit in {-2..+2}
   function automatic booth_sel_e booth_decode(input logic [2:0] trip);
      booth_sel_e sel;
      case (trip)
         3'b001, 3'b010: sel = SEL_PM;
         3'b011:         sel = SEL_P2M;
         3'b100:         sel = SEL_N2M;
         3'b101, 3'b110: sel = SEL_NM;
         default:        sel = SEL_ZERO;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/booth_mult_seq_cla_wide.sv
// (WIDTH+2)-bit adder: 8-bit CLA slices whose group generate/propagate
// terms drive a slice-level lookahead carry chain, plus a 2-bit top extension.
module cla_wide
   import booth_mult_seq_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH+1:0] a,
   input  logic [WIDTH+1:0] b,
   input  logic             c0,
   output logic [WIDTH+1:0] sum
);

   localparam int NSL = WIDTH / 8;

   logic [NSL-1:0] grp_g;
   logic [NSL-1:0] grp_p;
   logic [NSL:0]   carry;

   // Slice carries depend only on group G/P, never on another slice's ripple
   always_comb begin
      carry[0] = c0;
      for (int s = 0; s < NSL; s++)
         carry[s+1] = grp_g[s] | (grp_p[s] & carry[s]);
   end

   for (genvar s = 0; s < NSL; s++) begin : g_slice
      logic [7:0] g;
      logic [7:0] p;
      logic [7:0] sl;
      logic       gacc;
      logic       cy;

      assign g = a[s*8 +: 8] & b[s*8 +: 8];
      assign p = a[s*8 +: 8] ^ b[s*8 +: 8];

      always_comb begin
         gacc = 1'b0;
         for (int i = 0; i < 8; i++)
            gacc = g[i] | (p[i] & gacc);
      end

      always_comb begin
         cy = carry[s];
         sl = '0;
         for (int i = 0; i < 8; i++) begin
            sl[i] = p[i] ^ cy;
            cy    = g[i] | (p[i] & cy);
         end
      end

      assign grp_g[s]       = gacc;
      assign grp_p[s]       = &p;
      assign sum[s*8 +: 8]  = sl;
   end

   assign sum[WIDTH+1:WIDTH] = a[WIDTH+1:WIDTH] + b[WIDTH+1:WIDTH] + {1'b0, carry[NSL]};

endmodule

// File: rtl/booth_mult_seq.sv
// Radix-4 Booth sequential signed multiplier with start/ready handshake.
// Optional BOOTH_MULT_EARLY_ZERO_EN: a zero operand skips RUN entirely.
module booth_mult_seq
   import booth_mult_seq_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY
);

   localparam int AW = WIDTH + 2;
   localparam int PW = 2 * WIDTH + 3;
   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH / 2 - 1);

   logic [1:0]    state;
   logic [AW-1:0] m;
   logic [PW-1:0] p;
   logic [CW-1:0] cnt;

   booth_sel_e    sel;
   logic [AW-1:0] addend;
   logic          c_in;
   logic [AW-1:0] acc_sum;
   logic [PW-1:0] p_shift;
   logic          start_zero;
   logic          ovf;

   always_comb begin
      sel    = booth_decode(p[2:0]);
      addend = '0;
      c_in   = 1'b0;
      case (sel)
         SEL_PM:  addend = m;
         SEL_P2M: addend = {m[AW-2:0], 1'b0};
         SEL_NM:  begin addend = ~m;                 c_in = 1'b1; end
         SEL_N2M: begin addend = ~{m[AW-2:0], 1'b0}; c_in = 1'b1; end
         default: addend = '0;
      endcase
   end

   cla_wide #(.WIDTH(WIDTH)) u_add (
      .a   (p[PW-1 -: AW]),
      .b   (addend),
      .c0  (c_in),
      .sum (acc_sum)
   );

   assign p_shift = {{2{acc_sum[AW-1]}}, acc_sum, p[WIDTH:2]};

   // Product sits in p[2W:1]; it fits in WIDTH signed bits iff p[2W:W] is uniform
   assign ovf = ~((&p[2*WIDTH:WIDTH]) | ~(|p[2*WIDTH:WIDTH]));

`ifdef BOOTH_MULT_EARLY_ZERO_EN
   assign start_zero = (data_operandA == '0) || (data_operandB == '0);
`else
   assign start_zero = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (!reset) begin
         state          <= ST_IDLE;
         m              <= '0;
         p              <= '0;
         cnt            <= '0;
         data_result    <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
      end else begin
         data_resultRDY <= 1'b0;
         if (ctrl_MULT) begin
            // A start in any state discards whatever was in flight
            m   <= {{2{data_operandA[WIDTH-1]}}, data_operandA};
            cnt <= '0;
            if (start_zero) begin
               p     <= '0;
               state <= ST_DONE;
            end else begin
               p     <= {{AW{1'b0}}, data_operandB, 1'b0};
               state <= ST_RUN;
            end
         end else begin
            case (state)
               ST_RUN: begin
                  p   <= p_shift;
                  cnt <= cnt + CW'(1);
                  if (cnt == LAST)
                     state <= ST_DONE;
               end
               ST_DONE: begin
                  data_result    <= p[WIDTH:1];
                  data_exception <= ovf;
                  data_resultRDY <= 1'b1;
                  state          <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: spec vectors, random operands
// against a 64-bit arithmetic model, restart and mid-operation reset.
module tb_booth_mult_seq;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic        ctrl_MULT;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;

   int n_tests = 0;
   int n_fail  = 0;
   int pulses  = 0;

   booth_mult_seq #(.WIDTH(32)) dut (
      .clock          (clock),
      .reset          (reset),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .ctrl_MULT      (ctrl_MULT),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY)
   );

   always #5 clock = ~clock;

   always @(negedge clock) if (data_resultRDY) pulses++;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        exc;
   } vec_t;

   vec_t tbl[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic e);
      longint pr;
      logic [31:0] lo;
      pr = longint'(signed'(a)) * longint'(signed'(b));
      lo = pr[31:0];
      r  = lo;
      e  = (pr != longint'(signed'(lo)));
   endfunction

   function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef BOOTH_MULT_EARLY_ZERO_EN
      if (a == 0 || b == 0) return 1;
`endif
      return 17;
   endfunction

   // Pulse start for one edge, scramble operands, wait for ready and check everything
   task automatic run_mult(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] er, input logic ee);
      int lat;
      int p0;
      @(negedge clock);
      data_operandA = a; data_operandB = b; ctrl_MULT = 1'b1;
      p0 = pulses;
      @(posedge clock);
      @(negedge clock);
      ctrl_MULT = 1'b0;
      data_operandA = $urandom; data_operandB = $urandom;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clock); #1;
         if (data_resultRDY) begin lat = k; break; end
      end
      chk({name, " latency"}, lat, exp_lat(a, b));
      chk({name, " result"}, data_result, er);
      chk({name, " exception"}, {31'd0, data_exception}, {31'd0, ee});
      @(posedge clock); #1;
      chk({name, " one pulse"}, pulses - p0 + {31'd0, data_resultRDY}, 1);
   endtask

   initial begin
      logic [31:0] ra, rb, er;
      logic        ee;
      int          p0;
      int          lat;

      tbl[0] = '{32'd3,        32'd5,        32'h0000000F, 1'b0};
      tbl[1] = '{32'hFFFFFFF9, 32'd6,        32'hFFFFFFD6, 1'b0};
      tbl[2] = '{32'h00010000, 32'h00010000, 32'h00000000, 1'b1};
      tbl[3] = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
      tbl[4] = '{32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 1'b0};

      reset = 1'b0; ctrl_MULT = 1'b0; data_operandA = '0; data_operandB = '0;
      repeat (2) @(posedge clock);
      #1;
      chk("reset result", data_result, 32'd0);
      chk("reset exception", {31'd0, data_exception}, 32'd0);
      chk("reset ready", {31'd0, data_resultRDY}, 32'd0);
      @(negedge clock);
      reset = 1'b1;

      for (int i = 0; i < 5; i++)
         run_mult($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].exc);

      for (int i = 0; i < 30; i++) begin
         case ($urandom_range(0, 5))
            0: ra = 32'h80000000;
            1: ra = 32'h7FFFFFFF;
            2: ra = 32'd0;
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0: rb = 32'h80000000;
            1: rb = 32'hFFFFFFFF;
            2: rb = $urandom_range(0, 15);
            default: rb = $urandom;
         endcase
         model(ra, rb, er, ee);
         run_mult($sformatf("rand%0d", i), ra, rb, er, ee);
      end

      // Restart at edge 8 of a 3*5 operation with 4*4
      @(negedge clock);
      p0 = pulses;
      data_operandA = 32'd3; data_operandB = 32'd5; ctrl_MULT = 1'b1;
      @(posedge clock);
      @(negedge clock);
      ctrl_MULT = 1'b0;
      repeat (7) @(posedge clock);
      @(negedge clock);
      data_operandA = 32'd4; data_operandB = 32'd4; ctrl_MULT = 1'b1;
      @(posedge clock);
      @(negedge clock);
      ctrl_MULT = 1'b0;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clock); #1;
         if (data_resultRDY) begin lat = k; break; end
      end
      chk("restart latency", lat, 17);
      chk("restart result", data_result, 32'h10);
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("restart pulses", pulses - p0, 1);

      // Reset at edge 5 of an operation: outputs clear, no ready ever
      p0 = pulses;
      data_operandA = 32'd3; data_operandB = 32'd5; ctrl_MULT = 1'b1;
      @(posedge clock);
      @(negedge clock);
      ctrl_MULT = 1'b0;
      repeat (4) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock); #1;
      chk("abort result", data_result, 32'd0);
      chk("abort exception", {31'd0, data_exception}, 32'd0);
      chk("abort ready", {31'd0, data_resultRDY}, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      repeat (25) @(posedge clock);
      @(negedge clock);
      chk("abort pulses", pulses - p0, 0);

      // Fresh operation after abort still works
      run_mult("post_reset", 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd6, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
